// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, LSU and memory-side handshake signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory environment.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              instr_req_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [DATA_W-1:0] instr_rdata_o;
  logic              instr_err_o;

  logic              data_req_i;
  logic              data_we_i;
  logic [3:0]        data_be_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_err_i;

  logic              proto_err_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output proto_err_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  proto_err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between fetch and LSU, routing in-order responses back.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-over-instr priority.
module mem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(MAX_OUTSTANDING - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StHoldI, StHoldD} state_e;

  state_e                     state_q;
  logic [MAX_OUTSTANDING-1:0] ids_q;
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]            count_q;
  logic                       proto_err_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                       last_data_q;
`endif

  logic              sel_data, arb_data, sel_req, full, mem_req, push, pop, head;
  logic              we_sel;
  logic [3:0]        be_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    // On contention the side granted last yields.
    if (bus.data_req_i && bus.instr_req_i) arb_data = ~last_data_q;
    else                                   arb_data = bus.data_req_i;
`else
    arb_data = bus.data_req_i;
`endif
    unique case (state_q)
      StHoldI: sel_data = 1'b0;
      StHoldD: sel_data = 1'b1;
      default: sel_data = arb_data;
    endcase

    sel_req = sel_data ? bus.data_req_i : bus.instr_req_i;
    full    = (count_q == CntFull);
    mem_req = sel_req & ~full;
    push    = mem_req & bus.mem_gnt_i;
    pop     = bus.mem_rvalid_i & (count_q != '0);
    head    = ids_q[rd_ptr_q];

    addr_sel  = sel_data ? bus.data_addr_i  : bus.instr_addr_i;
    we_sel    = sel_data ? bus.data_we_i    : 1'b0;
    be_sel    = sel_data ? bus.data_be_i    : 4'hF;
    wdata_sel = sel_data ? bus.data_wdata_i : '0;
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = mem_req ? addr_sel  : '0;
  assign bus.mem_we_o    = mem_req ? we_sel    : 1'b0;
  assign bus.mem_be_o    = mem_req ? be_sel    : 4'h0;
  assign bus.mem_wdata_o = mem_req ? wdata_sel : '0;

  assign bus.instr_gnt_o = push & ~sel_data;
  assign bus.data_gnt_o  = push &  sel_data;

  assign bus.instr_rvalid_o = pop & ~head;
  assign bus.data_rvalid_o  = pop &  head;
  assign bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.data_rdata_o   = bus.data_rvalid_o  ? bus.mem_rdata_i : '0;
  assign bus.instr_err_o    = bus.instr_rvalid_o & bus.mem_err_i;
  assign bus.data_err_o     = bus.data_rvalid_o  & bus.mem_err_i;
  assign bus.proto_err_o    = proto_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ids_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_req && !bus.mem_gnt_i) state_q <= sel_data ? StHoldD : StHoldI;
        end
        // A dropped request also releases the hold; no grant is issued.
        StHoldI, StHoldD: begin
          if (!sel_req || bus.mem_gnt_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (push) begin
        ids_q[wr_ptr_q] <= sel_data;
        wr_ptr_q        <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        last_data_q     <= sel_data;
`endif
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;

      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;

      if (bus.mem_rvalid_i && count_q == '0) proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_OUTSTANDING=2).
// Expectations follow ARB_ROUND_ROBIN_EN when the same macro is defined for the bench.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .MAX_OUTSTANDING(2),
    .ADDR_W         (32),
    .DATA_W         (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven for the new cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'h0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.mem_err_i    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst = 1'b1;

    // Reset state
    #2;
    chk("rst_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
    chk("rst_gnts", {30'b0, bus.instr_gnt_o, bus.data_gnt_o}, 32'd0);
    chk("rst_rvalids", {30'b0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'd0);
    chk("rst_proto_err", {31'b0, bus.proto_err_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    cyc();
    cyc();
    rst = 1'b0;

    // Test 1: contention in IDLE, then the other side next cycle; fill to 2 outstanding
    cyc();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h200;
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'h3;
    bus.data_addr_i  = 32'h300;
    bus.data_wdata_i = 32'h55;
    bus.mem_gnt_i    = 1'b1;
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    chk("t1_instr_gnt", {31'b0, bus.instr_gnt_o}, 32'd1);
    chk("t1_data_gnt", {31'b0, bus.data_gnt_o}, 32'd0);
    chk("t1_mem_we", {31'b0, bus.mem_we_o}, 32'd0);
    chk("t1_mem_be", {28'b0, bus.mem_be_o}, 32'hF);
    chk("t1_mem_addr", bus.mem_addr_o, 32'h200);
`else
    chk("t1_data_gnt", {31'b0, bus.data_gnt_o}, 32'd1);
    chk("t1_instr_gnt", {31'b0, bus.instr_gnt_o}, 32'd0);
    chk("t1_mem_we", {31'b0, bus.mem_we_o}, 32'd1);
    chk("t1_mem_be", {28'b0, bus.mem_be_o}, 32'h3);
    chk("t1_mem_addr", bus.mem_addr_o, 32'h300);
    chk("t1_mem_wdata", bus.mem_wdata_o, 32'h55);
`endif
    cyc();
`ifdef ARB_ROUND_ROBIN_EN
    bus.instr_req_i = 1'b0;
    #1;
    chk("t1_second_data_gnt", {31'b0, bus.data_gnt_o}, 32'd1);
    chk("t1_second_instr_gnt", {31'b0, bus.instr_gnt_o}, 32'd0);
`else
    bus.data_req_i = 1'b0;
    #1;
    chk("t1_second_instr_gnt", {31'b0, bus.instr_gnt_o}, 32'd1);
    chk("t1_second_data_gnt", {31'b0, bus.data_gnt_o}, 32'd0);
    chk("t1_second_we", {31'b0, bus.mem_we_o}, 32'd0);
`endif
    // Full: request blocked even though rvalid pops this cycle
    cyc();
    idle_inputs();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h204;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h11;
    #1;
    chk("t1_full_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
    chk("t1_full_instr_gnt", {31'b0, bus.instr_gnt_o}, 32'd0);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t1_resp1_owner", {30'b0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b10);
    chk("t1_resp1_rdata", bus.instr_rdata_o, 32'h11);
`else
    chk("t1_resp1_owner", {30'b0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b01);
    chk("t1_resp1_rdata", bus.data_rdata_o, 32'h11);
`endif
    cyc();
    idle_inputs();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h22;
    bus.mem_err_i    = 1'b1;
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    chk("t1_resp2_owner", {30'b0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b01);
    chk("t1_resp2_err", {30'b0, bus.instr_err_o, bus.data_err_o}, 32'b01);
    chk("t1_resp2_rdata", bus.data_rdata_o, 32'h22);
`else
    chk("t1_resp2_owner", {30'b0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b10);
    chk("t1_resp2_err", {30'b0, bus.instr_err_o, bus.data_err_o}, 32'b10);
    chk("t1_resp2_rdata", bus.instr_rdata_o, 32'h22);
`endif

    // Test 2: instr held at 0x100 for 3 cycles while data starts requesting
    cyc();
    idle_inputs();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h100;
    #1;
    chk("t2_c0_mem_req", {31'b0, bus.mem_req_o}, 32'd1);
    chk("t2_c0_addr", bus.mem_addr_o, 32'h100);
    for (int i = 1; i < 3; i++) begin
      cyc();
      bus.data_req_i   = 1'b1;
      bus.data_we_i    = 1'b1;
      bus.data_be_i    = 4'hC;
      bus.data_addr_i  = 32'h400;
      bus.data_wdata_i = 32'hA5A5;
      #1;
      chk($sformatf("t2_c%0d_addr", i), bus.mem_addr_o, 32'h100);
      chk($sformatf("t2_c%0d_we", i), {31'b0, bus.mem_we_o}, 32'd0);
      chk($sformatf("t2_c%0d_data_gnt", i), {31'b0, bus.data_gnt_o}, 32'd0);
    end
    cyc();
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("t2_gnt_owner", {30'b0, bus.instr_gnt_o, bus.data_gnt_o}, 32'b10);
    chk("t2_gnt_addr", bus.mem_addr_o, 32'h100);

    // Test 4: count=1, new data grant and response in the same cycle
    cyc();
    bus.instr_req_i  = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hCAFE0001;
    #1;
    chk("t4_data_gnt", {31'b0, bus.data_gnt_o}, 32'd1);
    chk("t4_addr", bus.mem_addr_o, 32'h400);
    chk("t4_resp_owner", {30'b0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b10);
    chk("t4_resp_rdata", bus.instr_rdata_o, 32'hCAFE0001);
    // count stayed 1: one more response goes to data, next one would be a protocol error
    cyc();
    idle_inputs();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0BADF00D;
    #1;
    chk("t4_drain_owner", {30'b0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b01);
    chk("t4_drain_rdata", bus.data_rdata_o, 32'h0BADF00D);
    cyc();
    idle_inputs();
    #1;
    chk("t4_no_proto_err", {31'b0, bus.proto_err_o}, 32'd0);

    // Test 3: instr then data granted, third request blocked, responses in order
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h500;
    bus.mem_gnt_i    = 1'b1;
    #1;
    chk("t3_instr_gnt", {31'b0, bus.instr_gnt_o}, 32'd1);
    cyc();
    bus.instr_req_i = 1'b0;
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h600;
    #1;
    chk("t3_data_gnt", {31'b0, bus.data_gnt_o}, 32'd1);
    cyc();
    #1;
    chk("t3_third_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
    chk("t3_third_data_gnt", {31'b0, bus.data_gnt_o}, 32'd0);
    cyc();
    idle_inputs();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hDEADBEEF;
    #1;
    chk("t3_resp1_owner", {30'b0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b10);
    chk("t3_resp1_rdata", bus.instr_rdata_o, 32'hDEADBEEF);
    cyc();
    bus.mem_rdata_i = 32'h12345678;
    #1;
    chk("t3_resp2_owner", {30'b0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'b01);
    chk("t3_resp2_rdata", bus.data_rdata_o, 32'h12345678);

    // Test 5: rvalid with nothing outstanding
    cyc();
    bus.mem_rdata_i = 32'h77;
    #1;
    chk("t5_no_rvalid", {30'b0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'd0);
    cyc();
    idle_inputs();
    #1;
    chk("t5_proto_err_set", {31'b0, bus.proto_err_o}, 32'd1);
    cyc();
    cyc();
    chk("t5_proto_err_sticky", {31'b0, bus.proto_err_o}, 32'd1);

    // Test 6: reset with two outstanding drops them
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h700;
    bus.mem_gnt_i    = 1'b1;
    cyc();
    bus.instr_req_i = 1'b0;
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h800;
    #1;
    chk("t6_second_gnt", {31'b0, bus.data_gnt_o}, 32'd1);
    cyc();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("t6_rst_proto_err", {31'b0, bus.proto_err_o}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    bus.instr_req_i = 1'b1;
    #1;
    chk("t6_not_full", {31'b0, bus.mem_req_o}, 32'd1);
    bus.instr_req_i  = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h99;
    #1;
    chk("t6_no_rvalid", {30'b0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'd0);
    cyc();
    idle_inputs();
    #1;
    chk("t6_proto_err", {31'b0, bus.proto_err_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
